note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//   Song-pattern store and playback engine driven by the game mode FSM.
//   EDIT mode records up to NUM_NOTES lane patterns; DIFF mode latches tempo;
//   RUN mode replays patterns one step per beat and returns note_count,
//   which the mode FSM watches to enter FINISH at NUM_NOTES.
// PARAMETERS
//   NUM_NOTES  41   song length in steps; note_count saturates here
//   LANES      4    lane bits per step (one per fret button)
//   BASE_DIV   24   clk cycles per step at difficulty 0; width 24 bits
// PORTS
//   clk         in   1      system clock, rising edge
//   n_rst       in   1      asynchronous active-low reset
//   mode        in   3      FSM mode: 1 IDLE,2 EDIT,3 DIFF,4 RUN,5 PAUSE,6 FINISH
//   edit_lanes  in   LANES  pattern to record on edit_commit
//   edit_commit in   1      one-cycle pulse: write edit_lanes at wr_ptr
//   diff_sel    in   2      difficulty 0..3, sampled in DIFF
//   note_count  out  6      steps played so far, 0..NUM_NOTES
//   lanes_out   out  LANES  pattern of current step, registered
//   note_strobe out  1      one-cycle pulse when a new step is presented
// BEHAVIOUR
//   Reset (n_rst=0, async): note_count=0, lanes_out=0, note_strobe=0,
//     wr_ptr=0, diff_reg=0, div_cnt=0. Pattern RAM not reset (wr_ptr masks it).
//   Modes 0 and 7 behave exactly as IDLE.
//   IDLE: note_count, wr_ptr, div_cnt, lanes_out cleared; note_strobe=0.
//   EDIT: edit_commit=1 and wr_ptr<NUM_NOTES -> mem[wr_ptr]<=edit_lanes,
//     wr_ptr++ next cycle. wr_ptr==NUM_NOTES -> commit ignored (full).
//     edit_commit in any other mode ignored. div_cnt held at 0.
//   DIFF: diff_reg<=diff_sel every cycle; last value held on exit.
//   period = max(1, BASE_DIV >> diff_reg).
//   RUN: div_cnt counts 0..period-1 and wraps. On the cycle div_cnt==period-1
//     and note_count<NUM_NOTES, next edge: note_strobe=1,
//     lanes_out = (note_count<wr_ptr) ? mem[note_count] : 0 (rest),
//     note_count++. First strobe exactly period cycles after entering RUN
//     from DIFF. note_count==NUM_NOTES -> no strobes, counters hold.
//   PAUSE: div_cnt, note_count, lanes_out hold; note_strobe=0. RUN resumes
//     from the held div_cnt (no phase loss).
//   FINISH: note_count holds; lanes_out=0; note_strobe=0; div_cnt=0.
//   div_cnt cleared on any mode other than RUN/PAUSE.
//   note_strobe never high two consecutive cycles unless period==1.
//   Mode change RUN->PAUSE on a terminal-count cycle: strobe still issued
//     (decision registered from RUN cycle); no further step while paused.
//   Reset mid-RUN: all outputs to reset values immediately; wr_ptr=0, so the
//     song must be re-recorded.
//   note_count width fixed at 6; NUM_NOTES must be <=63.
// TESTING
//   Reset mid-operation -> note_count=0, lanes_out=0, note_strobe=0 async.
//   EDIT, 3 commits 4'b0001,4'b0010,4'b1000; RUN diff 0 -> strobes every 24
//     cycles, lanes_out 0001,0010,1000 then 0000 rests, note_count 1,2,3,4.
//   DIFF diff_sel=2 then RUN -> strobe period 6 cycles; diff_sel=3 -> 3.
//   RUN 10 cycles into step, PAUSE 100 cycles, RUN -> next strobe 14 cycles
//     after resume; no strobe during PAUSE.
//   RUN to completion -> note_count reaches 41 and holds; no 42nd strobe.
//   45 commits in EDIT -> only first 41 stored; commits in RUN ignored.

Source files
------------

// File: rtl/note_sequencer_if.sv
// Handshake bundle between the game mode FSM and the note sequencer.
// The FSM side drives mode and edit controls; the sequencer returns playback state.
interface note_sequencer_if #(
    parameter int unsigned LANES = 4
);
    logic [2:0]       mode;
    logic [LANES-1:0] edit_lanes;
    logic             edit_commit;
    logic [1:0]       diff_sel;
    logic [5:0]       note_count;
    logic [LANES-1:0] lanes_out;
    logic             note_strobe;

    modport master (
        output mode, edit_lanes, edit_commit, diff_sel,
        input  note_count, lanes_out, note_strobe
    );

    modport slave (
        input  mode, edit_lanes, edit_commit, diff_sel,
        output note_count, lanes_out, note_strobe
    );
endinterface

// File: rtl/note_sequencer.sv
// Song-pattern store and playback engine: records lane patterns in EDIT,
// latches tempo in DIFF and replays one step per beat in RUN.
module note_sequencer #(
    parameter int unsigned NUM_NOTES = 41,
    parameter int unsigned LANES     = 4,
    parameter int unsigned BASE_DIV  = 24
) (
    input logic             clk,
    input logic             n_rst,
    note_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        MODE_IDLE   = 3'd1,
        MODE_EDIT   = 3'd2,
        MODE_DIFF   = 3'd3,
        MODE_RUN    = 3'd4,
        MODE_PAUSE  = 3'd5,
        MODE_FINISH = 3'd6
    } mode_e;

    localparam logic [5:0]  LAST = 6'(NUM_NOTES);
    localparam logic [23:0] BASE = 24'(BASE_DIV);

    logic [LANES-1:0] mem [NUM_NOTES];

    logic [5:0]       count_q, count_d;
    logic [5:0]       wr_ptr_q, wr_ptr_d;
    logic [LANES-1:0] lanes_q, lanes_d;
    logic             strobe_q, strobe_d;
    logic [1:0]       diff_q, diff_d;
    logic [23:0]      div_q, div_d;
    logic [23:0]      shifted, period;
    logic             mem_we;

    always_comb begin
        shifted = BASE >> diff_q;
        period  = (shifted == '0) ? 24'd1 : shifted;
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        lanes_d  = lanes_q;
        strobe_d = 1'b0;
        diff_d   = diff_q;
        div_d    = div_q;
        mem_we   = 1'b0;
        case (bus.mode)
            MODE_EDIT: begin
                div_d = '0;
                if (bus.edit_commit && (wr_ptr_q < LAST)) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 6'd1;
                end
            end
            MODE_DIFF: begin
                diff_d = bus.diff_sel;
                div_d  = '0;
            end
            MODE_RUN: begin
                // Once the song is exhausted the divider freezes as well.
                if (count_q < LAST) begin
                    if (div_q == period - 24'd1) begin
                        div_d    = '0;
                        strobe_d = 1'b1;
                        count_d  = count_q + 6'd1;
                        lanes_d  = (count_q < wr_ptr_q) ? mem[count_q] : '0;
                    end else begin
                        div_d = div_q + 24'd1;
                    end
                end
            end
            MODE_PAUSE: begin
            end
            MODE_FINISH: begin
                lanes_d = '0;
                div_d   = '0;
            end
            default: begin
                count_d  = '0;
                wr_ptr_d = '0;
                lanes_d  = '0;
                div_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            lanes_q  <= '0;
            strobe_q <= 1'b0;
            diff_q   <= '0;
            div_q    <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            lanes_q  <= lanes_d;
            strobe_q <= strobe_d;
            diff_q   <= diff_d;
            div_q    <= div_d;
        end
    end

    // Pattern RAM is deliberately unreset; wr_ptr bounds which entries are valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= bus.edit_lanes;
        end
    end

    assign bus.note_count  = count_q;
    assign bus.lanes_out   = lanes_q;
    assign bus.note_strobe = strobe_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed phases with randomized
// patterns, compared against a queue-based song model.
module tb_note_sequencer;
    localparam int NUM = 41;

    logic clk = 1'b0;
    logic n_rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    logic [3:0] song[$];
    int         exp_count;
    int         diff_m;

    note_sequencer_if #(.LANES(4)) bus ();

    note_sequencer #(.NUM_NOTES(41), .LANES(4), .BASE_DIV(24)) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic int period_of(input int d);
        int p;
        p = 24 / (2 ** d);
        return (p < 1) ? 1 : p;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int cnt, input int lanes, input int strobe);
        check({tag, "_count"}, 32'(bus.note_count), 32'(cnt));
        check({tag, "_lanes"}, 32'(bus.lanes_out), 32'(lanes));
        check({tag, "_strobe"}, 32'(bus.note_strobe), 32'(strobe));
    endtask

    // Waits for the next strobe (bounded); optionally pokes commits that must be ignored.
    task automatic wait_strobe(input string tag, input int exp_gap, input bit poke);
        int   gap;
        logic [3:0] exp_l;
        gap = 0;
        do begin
            if (poke) begin
                bus.edit_lanes  = 4'($urandom_range(1, 15));
                bus.edit_commit = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            gap++;
        end while (!bus.note_strobe && gap < 200);
        bus.edit_commit = 1'b0;
        exp_l = (exp_count < song.size()) ? song[exp_count] : 4'd0;
        if (exp_count < NUM) exp_count++;
        check({tag, "_gap"}, 32'(gap), 32'(exp_gap));
        check({tag, "_lanes"}, 32'(bus.lanes_out), 32'(exp_l));
        check({tag, "_count"}, 32'(bus.note_count), 32'(exp_count));
    endtask

    task automatic quiet(input string tag, input int n);
        int s;
        s = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.note_strobe) s++;
        end
        check(tag, 32'(s), 32'd0);
    endtask

    task automatic commit(input logic [3:0] pat);
        bus.edit_lanes  = pat;
        bus.edit_commit = 1'b1;
        @(negedge clk);
        bus.edit_commit = 1'b0;
        if (song.size() < NUM) song.push_back(pat);
    endtask

    task automatic go_idle();
        bus.mode = 3'd1;
        @(negedge clk);
        song.delete();
        exp_count = 0;
    endtask

    task automatic set_diff(input int d);
        bus.mode     = 3'd3;
        bus.diff_sel = 2'(d);
        @(negedge clk);
        diff_m = d;
    endtask

    initial begin
        logic [3:0] pats [3];
        int         k;
        pats[0] = 4'b0001;
        pats[1] = 4'b0010;
        pats[2] = 4'b1000;

        n_rst           = 1'b0;
        bus.mode        = 3'd1;
        bus.edit_lanes  = '0;
        bus.edit_commit = 1'b0;
        bus.diff_sel    = '0;
        exp_count       = 0;
        diff_m          = 0;
        repeat (2) @(negedge clk);
        check_outputs("reset", 0, 0, 0);
        n_rst = 1'b1;
        @(negedge clk);

        // Three fixed patterns, then rests; commits poked during RUN must be ignored.
        bus.mode = 3'd2;
        @(negedge clk);
        for (int i = 0; i < 3; i++) commit(pats[i]);
        set_diff(0);
        bus.mode = 3'd4;
        for (int i = 0; i < 5; i++) wait_strobe($sformatf("d0_step%0d", i), period_of(diff_m), 1'b1);
        go_idle();
        check_outputs("idle_clear", 0, 0, 0);

        // 45 random commits: only the first 41 land; full playback at diff 2.
        bus.mode = 3'd2;
        @(negedge clk);
        for (int i = 0; i < 45; i++) begin
            commit(4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        set_diff(2);
        bus.mode = 3'd4;
        for (int i = 0; i < NUM; i++) wait_strobe($sformatf("d2_step%0d", i), period_of(diff_m), 1'b1);
        quiet("no_42nd_strobe", 40);
        check("count_saturated", 32'(bus.note_count), 32'(NUM));

        // Fastest tempo.
        go_idle();
        bus.mode = 3'd2;
        @(negedge clk);
        commit(4'($urandom_range(1, 15)));
        commit(4'($urandom_range(1, 15)));
        set_diff(3);
        bus.mode = 3'd4;
        for (int i = 0; i < 4; i++) wait_strobe($sformatf("d3_step%0d", i), period_of(diff_m), 1'b0);

        // Pause 10 cycles into a step; the divider phase must survive.
        go_idle();
        set_diff(0);
        bus.mode = 3'd4;
        wait_strobe("pause_first", 24, 1'b0);
        quiet("pre_pause", 10);
        bus.mode = 3'd5;
        quiet("during_pause", 100);
        check("pause_count_held", 32'(bus.note_count), 32'(exp_count));
        bus.mode = 3'd4;
        wait_strobe("resume", 14, 1'b0);

        // Asynchronous reset mid-RUN after a random-tempo recording.
        go_idle();
        bus.mode = 3'd2;
        @(negedge clk);
        for (int i = 0; i < 5; i++) commit(4'($urandom_range(1, 15)));
        k = int'($urandom_range(0, 3));
        set_diff(k);
        bus.mode = 3'd4;
        for (int i = 0; i < 2; i++) wait_strobe($sformatf("rnd_step%0d", i), period_of(diff_m), 1'b0);
        repeat (2) @(negedge clk);
        #2 n_rst = 1'b0;
        #1 check_outputs("async_reset", 0, 0, 0);
        @(negedge clk);
        n_rst = 1'b1;
        song.delete();
        exp_count = 0;
        diff_m    = 0;
        wait_strobe("post_reset", period_of(diff_m), 1'b0);

        // FINISH holds the count and blanks lanes; mode 7 acts as IDLE.
        bus.mode = 3'd6;
        @(negedge clk);
        check_outputs("finish", exp_count, 0, 0);
        quiet("finish_quiet", 30);
        bus.mode = 3'd7;
        @(negedge clk);
        check("mode7_clear", 32'(bus.note_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
